neuron_mac: RTL and testbench
=============================

// Module: neuron_mac
// PURPOSE
//  Sequential multiply-accumulate neuron stage directly upstream of the sigmoid
//  activation. Consumes N_INPUTS (activation, weight) pairs over a valid/ready
//  stream and adds them to a bias. Emits the saturated signed Q8.24 pre-activation
//  sum x, which feeds the sigmoid x input. One pair is accepted per cycle at most.
// PARAMETERS
//  WIDTH     32  data width of activations, weights, bias and result (signed)
//  FRAC      24  fractional bits (Q8.24); 1.0 = 32'h0100_0000
//  N_INPUTS  4   number of pairs per neuron evaluation (>=1)
//  ACC_W     48  accumulator width; must be >= 2*WIDTH-FRAC+1+clog2(N_INPUTS)
// PORTS
//  clk        in   1      clock; all state updates on its rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      begin an evaluation; sampled only in IDLE
//  bias       in   WIDTH  signed Q8.24 bias, captured on an accepted start
//  in_valid   in   1      in_x/in_w pair valid
//  in_ready   out  1      block can accept a pair
//  in_x       in   WIDTH  signed Q8.24 activation
//  in_w       in   WIDTH  signed Q8.24 weight
//  out_valid  out  1      out_z holds a finished result
//  out_ready  in   1      downstream (sigmoid) accepts out_z
//  out_z      out  WIDTH  signed Q8.24 saturated sum, to sigmoid x
//  out_sat    out  1      saturation occurred on this result
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, acc=0, cnt=0; in_ready=0,
//   out_valid=0, out_z=0, out_sat=0. Reset mid-evaluation discards partial sum.
//  FSM states: IDLE, ACCUM, OUT. The outputs are registered or pure functions of
//   the state.
//  IDLE: in_ready=0, out_valid=0. If start=1, then acc<=sign-extended bias,
//   cnt<=0, and the state moves to ACCUM.
//  ACCUM: in_ready=1. A pair is accepted on a cycle where in_valid && in_ready:
//   prod = in_x*in_w as a full 2*WIDTH signed product (Q16.48).
//   term = prod >>> FRAC. This is an arithmetic shift, i.e. floor toward -inf;
//   no rounding.
//   acc <= acc + sext(term); cnt <= cnt+1.
//   When the accepted pair is number N_INPUTS (cnt==N_INPUTS-1), the state moves
//   to OUT. On the same edge: out_z <= sat(acc+term) and out_sat is set.
//   in_valid=0 cycles are stalls with no state change.
//  sat(): if value > 2^31-1, result = 32'h7FFF_FFFF. If value < -2^31, result =
//   32'h8000_0000. Otherwise the low WIDTH bits. out_sat=1 only when clamped.
//  OUT: out_valid=1 and in_ready=0. out_z/out_sat are held stable until
//   out_valid && out_ready. On that cycle the state moves to IDLE and out_valid
//   falls next cycle. A start in that same cycle is ignored.
//  Latency: out_valid rises on the edge that accepts the last pair. Minimum
//   start-to-result time is N_INPUTS+1 cycles.
//  start outside IDLE is ignored, including mid-ACCUM; bias is not re-sampled.
//  The accumulator never wraps within the stated ACC_W constraint. Saturation
//   applies only at output.
// TESTING
//  T1 basic: bias=32'h0080_0000, 4 pairs x=32'h0100_0000, w=32'h0040_0000
//     -> out_z=32'h0180_0000 (1.5), out_sat=0, out_valid 5 cycles after start.
//  T2 saturation: bias=0, 4 pairs x=32'h6400_0000 (100.0), w=32'h6400_0000
//     -> out_z=32'h7FFF_FFFF, out_sat=1; same with x=-100.0 -> 32'h8000_0000.
//  T3 truncation: bias=0, pairs (32'h0000_0001,32'h0080_0000) x4 -> out_z=0;
//     pairs (32'hFFFF_FFFF,32'h0080_0000) x4 -> out_z=32'hFFFF_FFFC.
//  T4 handshake: in_valid toggled 1/0 between pairs and out_ready held low 5
//     cycles -> result identical to T1. out_z stable while held, in_ready=0 in
//     OUT, and start pulses during ACCUM/OUT are ignored.
//  T5 reset: assert rst_n=0 after 2 accepted pairs -> all outputs 0, IDLE. A new
//     start with T1 stimulus -> out_z=32'h0180_0000.
//  T6 back-to-back: start asserted the cycle after out_valid&&out_ready for two
//     evaluations (T1 then T2 data) -> two correct results, no carry-over in acc.

Source files
------------

// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
// Sequential multiply-accumulate stage feeding the sigmoid x input.
// An accepted start loads the sign-extended bias into the accumulator. After
// that, N_INPUTS (activation, weight) pairs are accepted over a valid/ready
// stream. Each product is floored back to Q8.24 and added to the accumulator.
// The final sum is saturated to WIDTH bits and held until downstream takes it.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin an evaluation (only honoured in IDLE)
//   bias       in   WIDTH  signed Q8.24 bias, captured with an accepted start
//   in_valid   in   1      in_x/in_w pair valid
//   in_ready   out  1      block accepts a pair (high only in ACCUM)
//   in_x       in   WIDTH  signed Q8.24 activation
//   in_w       in   WIDTH  signed Q8.24 weight
//   out_valid  out  1      out_z holds a finished result (high only in OUT)
//   out_ready  in   1      downstream accepts out_z
//   out_z      out  WIDTH  signed Q8.24 saturated sum
//   out_sat    out  1      result was clamped
// -----------------------------------------------------------------------------
module neuron_mac #(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 24,
   parameter int N_INPUTS = 4,
   parameter int ACC_W    = 48
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] bias,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_x,
   input  logic signed [WIDTH-1:0] in_w,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic        [WIDTH-1:0] out_z,
   output logic                    out_sat
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   localparam int                 CNT_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N_INPUTS - 1);

   // Clamp an accumulator value to WIDTH signed bits; MSB of the result is
   // the "clamped" flag. The value fits exactly when every bit from the
   // accumulator MSB down to bit WIDTH-1 agrees with the sign.
   function automatic logic [WIDTH:0] sat_fn(input logic signed [ACC_W-1:0] v);
      logic [ACC_W-WIDTH:0] hi;
      hi = v[ACC_W-1:WIDTH-1];
      if ((hi == '0) || (hi == '1)) begin
         sat_fn = {1'b0, v[WIDTH-1:0]};
      end else if (v[ACC_W-1]) begin
         sat_fn = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         sat_fn = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
      end
   endfunction

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic        [CNT_W-1:0]   cnt_q, cnt_d;
   logic        [WIDTH-1:0]   out_z_q, out_z_d;
   logic                      out_sat_q, out_sat_d;

   logic signed [2*WIDTH-1:0] prod_s;
   logic signed [2*WIDTH-1:0] term_full_s;
   logic signed [ACC_W-1:0]   term_s;
   logic signed [ACC_W-1:0]   sum_s;
   logic signed [ACC_W-1:0]   bias_ext_s;

   // Full-precision product, floored to Q8.24 by arithmetic shift (no rounding).
   always_comb begin
      prod_s      = (2*WIDTH)'(in_x) * (2*WIDTH)'(in_w);
      term_full_s = prod_s >>> FRAC;
      term_s      = ACC_W'(term_full_s);
      sum_s       = acc_q + term_s;
      bias_ext_s  = ACC_W'(bias);
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      out_z_d   = out_z_q;
      out_sat_d = out_sat_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = bias_ext_s;
               cnt_d   = '0;
               state_d = S_ACCUM;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               acc_d = sum_s;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  // Result is registered on the same edge as the last pair.
                  {out_sat_d, out_z_d} = sat_fn(sum_s);
                  state_d              = S_OUT;
               end else begin
                  state_d = S_ACCUM;
               end
            end else begin
               state_d = S_ACCUM;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_OUT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         out_z_q   <= '0;
         out_sat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         out_z_q   <= out_z_d;
         out_sat_q <= out_sat_d;
      end
   end

   assign in_ready  = (state_q == S_ACCUM);
   assign out_valid = (state_q == S_OUT);
   assign out_z     = out_z_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac
// Directed stimulus for neuron_mac. Expected results are queued when an
// evaluation is issued; a monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_neuron_mac;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] bias = 32'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_x = 32'h0;
   logic [31:0] in_w = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_z;
   logic        out_sat;

   neuron_mac #(.WIDTH(32), .FRAC(24), .N_INPUTS(4), .ACC_W(48)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bias      (bias),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_w      (in_w),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   logic [32:0] exp_q[$];

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec = n_vec + 1;
      if (act !== expv) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Scoreboard monitor: one pop per output handshake, sampled on the falling edge.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL unexpected_result: got %h expected no result", out_z);
         end else begin
            e = exp_q.pop_front();
            check("out_z", out_z, e[31:0]);
            check("out_sat", {31'b0, out_sat}, {31'b0, e[32]});
         end
      end
   end

   task automatic do_start(input logic [31:0] b);
      start = 1'b1;
      bias  = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pair(input logic [31:0] x, input logic [31:0] w);
      in_valid = 1'b1;
      in_x     = x;
      in_w     = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid, then let the handshake edge pass.
   task automatic finish_eval(output int seen_cyc);
      int k;
      k = 0;
      while (!out_valid && k < 20) begin
         @(posedge clk); #1;
         k = k + 1;
      end
      seen_cyc = cyc;
      if (!out_valid) begin
         n_vec = n_vec + 1;
         n_bad = n_bad + 1;
         $display("FAIL out_valid_timeout: got 0 expected 1 within 20 cycles");
      end else begin
         out_ready = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic run_eval(input logic [31:0] b, input logic [31:0] x,
                           input logic [31:0] w, input logic [32:0] expv);
      int t;
      exp_q.push_back(expv);
      do_start(b);
      repeat (4) pair(x, w);
      finish_eval(t);
   endtask

   initial begin
      int s_cyc;
      int r_cyc;

      // Reset state
      #12;
      check("rst_in_ready", {31'b0, in_ready}, 32'h0);
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("rst_out_z", out_z, 32'h0);
      check("rst_out_sat", {31'b0, out_sat}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // T1 basic with latency check: 0.5 + 4*(1.0*0.25) = 1.5
      exp_q.push_back({1'b0, 32'h0180_0000});
      do_start(32'h0080_0000);
      s_cyc = cyc;
      check("t1_in_ready", {31'b0, in_ready}, 32'h1);
      repeat (3) pair(32'h0100_0000, 32'h0040_0000);
      check("t1_no_early_valid", {31'b0, out_valid}, 32'h0);
      pair(32'h0100_0000, 32'h0040_0000);
      finish_eval(r_cyc);
      // start edge + 4 pair edges: result present 5 cycles after start
      check("t1_latency", r_cyc - s_cyc, 32'd4);

      // T2 saturation both directions
      run_eval(32'h0, 32'h6400_0000, 32'h6400_0000, {1'b1, 32'h7FFF_FFFF});
      run_eval(32'h0, 32'h9C00_0000, 32'h6400_0000, {1'b1, 32'h8000_0000});

      // T3 floor truncation
      run_eval(32'h0, 32'h0000_0001, 32'h0080_0000, {1'b0, 32'h0000_0000});
      run_eval(32'h0, 32'hFFFF_FFFF, 32'h0080_0000, {1'b0, 32'hFFFF_FFFC});

      // T4 handshake: gaps, held output, ignored starts
      out_ready = 1'b0;
      exp_q.push_back({1'b0, 32'h0180_0000});
      do_start(32'h0080_0000);
      pair(32'h0100_0000, 32'h0040_0000);
      start = 1'b1; bias = 32'h7000_0000;     // gap cycle, start during ACCUM
      @(posedge clk); #1;
      start = 1'b0;
      pair(32'h0100_0000, 32'h0040_0000);
      @(posedge clk); #1;                      // gap cycle
      pair(32'h0100_0000, 32'h0040_0000);
      @(posedge clk); #1;                      // gap cycle
      pair(32'h0100_0000, 32'h0040_0000);
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_valid", {31'b0, out_valid}, 32'h1);
         check("t4_hold_in_ready", {31'b0, in_ready}, 32'h0);
         check("t4_hold_z", out_z, 32'h0180_0000);
         check("t4_hold_sat", {31'b0, out_sat}, 32'h0);
         start = (i == 2);
         @(posedge clk); #1;
      end
      start     = 1'b1;                        // start on the handshake cycle
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("t4_idle_in_ready", {31'b0, in_ready}, 32'h0);
      check("t4_idle_out_valid", {31'b0, out_valid}, 32'h0);

      // T5 reset mid-evaluation
      do_start(32'h0080_0000);
      pair(32'h0100_0000, 32'h0040_0000);
      pair(32'h0100_0000, 32'h0040_0000);
      rst_n = 1'b0;
      #1;
      check("t5_in_ready", {31'b0, in_ready}, 32'h0);
      check("t5_out_valid", {31'b0, out_valid}, 32'h0);
      check("t5_out_z", out_z, 32'h0);
      check("t5_out_sat", {31'b0, out_sat}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_eval(32'h0080_0000, 32'h0100_0000, 32'h0040_0000, {1'b0, 32'h0180_0000});

      // T6 back-to-back: second start lands in the IDLE cycle right after the handshake
      run_eval(32'h0080_0000, 32'h0100_0000, 32'h0040_0000, {1'b0, 32'h0180_0000});
      run_eval(32'h0, 32'h6400_0000, 32'h6400_0000, {1'b1, 32'h7FFF_FFFF});
      run_eval(32'h0080_0000, 32'h0100_0000, 32'h0040_0000, {1'b0, 32'h0180_0000});

      @(posedge clk); #1;
      check("sb_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
